// File: rtl/parity_sweep_checker.sv
// parity_sweep_checker: sweeps X3X2X1 over all 8 vectors, checks F against odd parity, reports errors via Start/Done.
// Ports: Clock, Reset (async, active-high), Start (run request, IDLE only), F (function output under check);
// X1..X3 (stimulus = Vec[0..2]), Busy, Done (1-cycle pulse), Pass, ErrCount (saturating),
// FailValid/FailVec/FailF (first failing vector {X3,X2,X1} and the F seen there).
module parity_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES = 1,
  parameter int ERR_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             F,
  output logic             X1,
  output logic             X2,
  output logic             X3,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrCount,
  output logic             FailValid,
  output logic [2:0]       FailVec,
  output logic             FailF
);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, CHECK = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [2:0] vec_q, vec_d, fvec_q, fvec_d;
  logic [3:0] pcnt_q, pcnt_d, settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic fvalid_q, fvalid_d, ff_q, ff_d, pass_q, pass_d, mismatch;
  assign mismatch = F != ^vec_q;
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    pcnt_d = pcnt_q;
    settle_d = settle_q;
    err_d = err_q;
    fvalid_d = fvalid_q;
    fvec_d = fvec_q;
    ff_d = ff_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: if (Start) begin
        err_d = '0;
        fvalid_d = 1'b0;
        fvec_d = 3'd0;
        ff_d = 1'b0;
        pass_d = 1'b0;
        vec_d = 3'd0;
        pcnt_d = 4'd0;
        settle_d = 4'(SETTLE_CYCLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = settle_q == 4'd0 ? CHECK : SETTLE;
        settle_d = settle_q == 4'd0 ? settle_q : settle_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q == '1 ? err_q : err_q + ERR_W'(1);
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d = vec_q;
            ff_d = F;
          end
        end
        settle_d = 4'(SETTLE_CYCLES);
        if (vec_q != 3'd7) begin
          vec_d = vec_q + 3'd1;
          state_d = SETTLE;
        end else if (pcnt_q != 4'(PASSES - 1)) begin
          pcnt_d = pcnt_q + 4'd1;
          vec_d = 3'd0;
          state_d = SETTLE;
        end else begin
          // Pass is resolved on entry to DONE so it is valid alongside the Done pulse
          pass_d = err_d == '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      vec_q <= 3'd0;
      pcnt_q <= 4'd0;
      settle_q <= 4'd0;
      err_q <= '0;
      fvalid_q <= 1'b0;
      fvec_q <= 3'd0;
      ff_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      pcnt_q <= pcnt_d;
      settle_q <= settle_d;
      err_q <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q <= fvec_d;
      ff_q <= ff_d;
      pass_q <= pass_d;
    end
  end
  assign {X3, X2, X1} = vec_q;
  assign Busy = state_q == SETTLE || state_q == CHECK;
  assign Done = state_q == DONE;
  assign Pass = pass_q;
  assign ErrCount = err_q;
  assign FailValid = fvalid_q;
  assign FailVec = fvec_q;
  assign FailF = ff_q;
endmodule

// File: doc/parity_sweep_checker.md
Name: parity_sweep_checker

Overview:
- Sequential stimulus and response stage wrapped around the 3-input product-of-sums function block (odd-parity truth table: F=1 for X3X2X1 = 001, 010, 100, 111).
- Drives X1/X2/X3 upstream of the function block, sweeping all 8 input vectors.
- Samples the returned F after a settle delay and compares it against the odd-parity golden value.
- Reports error count, first failing vector, and pass/fail status via a Start/Done handshake.

Parameters:
- SETTLE_CYCLES, default 1: extra cycles X is held before F is sampled; legal range 0..15.
- PASSES, default 1: number of full 8-vector sweeps per run; legal range 1..15.
- ERR_W, default 8: width of the ErrCount register.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a run; sampled only in IDLE.
- F  input  1  function-block output under check.
- X1  output  1  stimulus bit 0, equal to Vec[0].
- X2  output  1  stimulus bit 1, equal to Vec[1].
- X3  output  1  stimulus bit 2, equal to Vec[2].
- Busy  output  1  high from the cycle after Start is accepted through the last CHECK cycle.
- Done  output  1  one-cycle pulse at end of run.
- Pass  output  1  high when the last run had ErrCount==0; held until the next accepted Start.
- ErrCount  output  ERR_W  mismatch count, saturating.
- FailValid  output  1  a failing vector has been captured.
- FailVec  output  3  first failing vector, as {X3,X2,X1}.
- FailF  output  1  F value observed at the first failure.

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-high.
- Reset (takes effect immediately, including mid-run):
  - State=IDLE, Vec=0, so X1=X2=X3=0.
  - Busy=0, Done=0, Pass=0, ErrCount=0, FailValid=0, FailVec=0, FailF=0.
  - Pass counter=0, settle counter=0.
- F is treated as combinational from the registered X outputs on the same clock. No synchronizer is used.
- IDLE:
  - Start=1 → clear ErrCount, FailValid, FailVec, FailF, Pass; Vec=0; pass counter=0; settle counter=SETTLE_CYCLES; go to SETTLE.
  - Start=0 → stay in IDLE; all status outputs hold.
- SETTLE:
  - Counter==0 → go to CHECK; otherwise decrement.
  - SETTLE therefore lasts SETTLE_CYCLES+1 cycles. Vec is stable throughout.
- CHECK (1 cycle):
  - expected = Vec[0]^Vec[1]^Vec[2].
  - If F!=expected: ErrCount+1, saturating at 2^ERR_W-1. If FailValid==0, also capture FailVec=Vec, FailF=F, FailValid=1.
  - Vec!=7 → Vec+1, reload settle counter, go to SETTLE.
  - Vec==7 and pass counter!=PASSES-1 → pass counter+1, Vec=0 (wraps), reload, go to SETTLE.
  - Vec==7 and last pass → go to DONE. Vec holds at 7.
- DONE (1 cycle):
  - Done=1; Pass=(ErrCount==0); Busy=0.
  - Next state is IDLE. Start asserted during DONE is ignored.
- Start while Busy: ignored, with no restart and no effect on counters.
- Run length:
  - Each vector occupies SETTLE_CYCLES+2 cycles.
  - Busy is high for 8*PASSES*(SETTLE_CYCLES+2) cycles.
  - Done pulses on the following cycle.
- Suggested state encoding: 2-bit (IDLE, SETTLE, CHECK, DONE). Any encoding is acceptable if the above timing holds.

Test Plan:
1. F driven by a correct odd-parity model; SETTLE_CYCLES=1, PASSES=1; 1-cycle Start pulse → X steps 000..111, each vector held 3 cycles; Busy high 24 cycles; single Done pulse; Pass=1, ErrCount=0, FailValid=0.
2. F stuck at 0 → ErrCount=4, FailValid=1, FailVec=3'b001, FailF=0, Pass=0.
3. F = inverted parity; PASSES=3 → ErrCount=24, FailVec=3'b000, FailF=1; Vec wraps 7→0 twice; Busy high 72 cycles.
4. ERR_W=2, F stuck at 1, PASSES=2 → 8 mismatches; ErrCount saturates at 3 with no wrap to 0; FailVec=3'b000.
5. Reset asserted asynchronously mid-run at Vec=5 → all outputs 0 before the next clock edge; module in IDLE; a new Start then runs a clean sweep from 000.
6. Start re-asserted while Busy, and again during the Done cycle → ignored, no restart. Start held continuously after IDLE is re-entered → exactly one new run begins.
